// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter slice: frame length, FSM states,
// and a width helper.
package uart_tx_arbiter_pkg;

   localparam int unsigned FRAME_BITS = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   function automatic int unsigned width_min1(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping at
// NUM_REQ-1, and returns the first asserted request as a one-hot pick.
module uart_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = width_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               valid,
   output logic [NUM_REQ-1:0] pick
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      valid = 1'b0;
      pick  = '0;
      sum   = '0;
      idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         // last+k never exceeds 2*NUM_REQ-1, so a single subtract wraps it
         sum = {1'b0, last} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         idx = sum[IDX_W-1:0];
         if (!valid && req[idx]) begin
            valid     = 1'b1;
            pick[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters; after
// each grant it blocks further grants for one frame time with its own counter.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned FRAME_CYCLES = FRAME_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   output logic                 busy,
   output logic [15:0]          frame_count
);

   localparam int unsigned IDX_W = width_min1(NUM_REQ);
   localparam int unsigned CNT_W = width_min1(FRAME_CYCLES);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     win_idx_q, win_idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic                 tx_start_q, tx_start_d;
   logic                 busy_q, busy_d;

   logic                 pick_valid;
   logic [NUM_REQ-1:0]   pick_oh;
   logic [IDX_W-1:0]     pick_idx;
   logic [7:0]           pick_byte;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_valid),
      .pick  (pick_oh)
   );

   always_comb begin
      pick_idx  = '0;
      pick_byte = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) begin
            pick_idx  = IDX_W'(i);
            pick_byte = req_data[8*i +: 8];
         end
      end
   end

   // Grant, start and data are loaded on the IDLE->ISSUE edge so that every
   // output comes straight from a flop and is valid throughout ISSUE.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      win_idx_d   = win_idx_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      tx_data_d   = tx_data_q;
      gnt_d       = '0;
      tx_start_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d    = ST_ISSUE;
               win_idx_d  = pick_idx;
               tx_data_d  = pick_byte;
               gnt_d      = pick_oh;
               tx_start_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            cnt_d       = CNT_W'(FRAME_CYCLES - 1);
            last_d      = win_idx_q;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            // Leaving on the cycle the count reaches zero yields FRAME_CYCLES-1 WAIT cycles
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         last_q      <= IDX_W'(NUM_REQ - 1);
         win_idx_q   <= '0;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
         tx_data_q   <= '0;
         gnt_q       <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         win_idx_q   <= win_idx_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         tx_data_q   <= tx_data_d;
         gnt_q       <= gnt_d;
         tx_start_q  <= tx_start_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt         = gnt_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign busy        = busy_q;
   assign frame_count = frame_cnt_q;

endmodule
